// File: rtl/adder_operand_sequencer_if.sv
// Stream and adder-side signals of the word-serial adder sequencer.
// master = the sequencer itself, slave = the surrounding environment.
interface adder_operand_sequencer_if #(
    parameter int WIDTH = 128,
    parameter int WORD  = 32
);
    // Both streams: a beat transfers on a rising edge where valid && ready;
    // valid never depends on ready, and a raised valid holds with stable payload until it transfers.
    logic             in_valid;
    logic             in_ready;
    logic [WORD-1:0]  in_data;
    logic             in_cin;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WORD-1:0]  out_data;
    logic             out_last;
    logic             out_cout;
    logic             busy;
    logic [1:0]       dbg_state;

    modport master (
        input  in_valid, in_data, in_cin, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_data, out_last,
               out_cout, busy, dbg_state
    );

    modport slave (
        output in_valid, in_data, in_cin, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_data, out_last,
               out_cout, busy, dbg_state
    );
endinterface

// File: rtl/adder_operand_sequencer.sv
// Word-serial operand loader and result streamer wrapped around an external
// combinational WIDTH-bit adder.
module adder_operand_sequencer #(
    parameter int WIDTH = 128,
    parameter int WORD  = 32
) (
    input logic                       clk,
    input logic                       reset,
    adder_operand_sequencer_if.master bus
);
    localparam int WORDS = WIDTH / WORD;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic [WIDTH-1:0] res_q;
    logic             cout_q;
    logic             last_beat;

    assign last_beat = (idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= LOAD_A;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            res_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                LOAD_A: if (bus.in_valid) begin
                    a_q[idx*WORD +: WORD] <= bus.in_data;
                    if (idx == '0) cin_q <= bus.in_cin;
                    if (last_beat) begin
                        idx   <= '0;
                        state <= LOAD_B;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                LOAD_B: if (bus.in_valid) begin
                    b_q[idx*WORD +: WORD] <= bus.in_data;
                    if (last_beat) begin
                        idx   <= '0;
                        state <= CAPTURE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                // Adder inputs have been stable from registers for a full cycle here.
                CAPTURE: begin
                    res_q  <= bus.add_sum;
                    cout_q <= bus.add_cout;
                    state  <= SEND;
                end
                SEND: if (bus.out_ready) begin
                    if (last_beat) begin
                        idx   <= '0;
                        state <= LOAD_A;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

    assign bus.in_ready  = !reset && ((state == LOAD_A) || (state == LOAD_B));
    assign bus.add_a     = a_q;
    assign bus.add_b     = b_q;
    assign bus.add_cin   = cin_q;
    assign bus.out_valid = (state == SEND);
    assign bus.out_data  = res_q[idx*WORD +: WORD];
    assign bus.out_last  = (state == SEND) && last_beat;
    assign bus.out_cout  = cout_q;
    assign bus.busy      = !((state == LOAD_A) && (idx == '0));
    assign bus.dbg_state = state;
endmodule
